// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared FSM state type and counter sizing for the PLL lock supervisor.
package pll_sup_pkg;
    typedef enum logic [2:0] {IDLE, RST, WAIT, LOCKED, FAIL} pll_sup_state_t;
    function automatic int f_cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction
endpackage

// File: rtl/pll_sup_chan.sv
// pll_sup_chan: one PLL's lock synchronizer, reset/wait/retry FSM and, with PLL_SUP_LOST_CNT_EN, a saturating lost-lock counter.
module pll_sup_chan
    import pll_sup_pkg::*;
#(
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int RST_CYCLES    = 16,
    parameter int MAX_RETRY     = 3,
    parameter int STABLE_CYCLES = 8
`ifdef PLL_SUP_LOST_CNT_EN
    , parameter int CNT_W       = 8
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic pll_lock,
    output logic pll_rst_o,
    output logic locked,
    output logic fail,
    output logic lost_pulse
`ifdef PLL_SUP_LOST_CNT_EN
    , output logic [CNT_W-1:0] lost_cnt
`endif
);
    localparam int TW = $clog2(LOCK_TIMEOUT);
    localparam int RW = f_cnt_w(RST_CYCLES);
    localparam int SW = f_cnt_w(STABLE_CYCLES);
    localparam int QW = f_cnt_w(MAX_RETRY);
    pll_sup_state_t r_state;
    logic [1:0]    r_sync;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_rcnt;
    logic [SW-1:0] r_stable;
    logic [QW-1:0] r_retry;
    logic          r_rst, r_locked, r_fail, r_lost;
    logic          w_lock_s;
    assign w_lock_s   = r_sync[1];
    assign pll_rst_o  = r_rst;
    assign locked     = r_locked;
    assign fail       = r_fail;
    assign lost_pulse = r_lost;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sync   <= '0;
            r_timer  <= '0;
            r_rcnt   <= '0;
            r_stable <= '0;
            r_retry  <= '0;
            r_rst    <= 1'b0;
            r_locked <= 1'b0;
            r_fail   <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], pll_lock};
            r_lost <= 1'b0;
            if (!en) begin
                r_state  <= IDLE;
                r_rst    <= 1'b0;
                r_locked <= 1'b0;
                r_fail   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= RST;
                        r_rst   <= 1'b1;
                        r_rcnt  <= '0;
                        r_retry <= '0;
                    end
                    RST: begin
                        if (r_rcnt == RW'(RST_CYCLES - 1)) begin
                            r_state  <= WAIT;
                            r_rst    <= 1'b0;
                            r_timer  <= '0;
                            r_stable <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + RW'(1);
                        end
                    end
                    WAIT: begin
                        r_timer  <= (r_timer == TW'(LOCK_TIMEOUT - 1)) ? r_timer : r_timer + TW'(1);
                        r_stable <= w_lock_s ? r_stable + SW'(1) : '0;
                        // a qualified lock takes precedence over a timeout in the same cycle
                        if (w_lock_s && r_stable == SW'(STABLE_CYCLES - 1)) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                            r_retry  <= '0;
                        end else if (r_timer == TW'(LOCK_TIMEOUT - 1)) begin
                            if (r_retry < QW'(MAX_RETRY)) begin
                                r_state <= RST;
                                r_rst   <= 1'b1;
                                r_rcnt  <= '0;
                                r_retry <= r_retry + QW'(1);
                            end else begin
                                r_state <= FAIL;
                                r_fail  <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!w_lock_s) begin
                            r_state  <= RST;
                            r_locked <= 1'b0;
                            r_lost   <= 1'b1;
                            r_rst    <= 1'b1;
                            r_rcnt   <= '0;
                            r_retry  <= '0;
                        end
                    end
                    FAIL:    r_state <= FAIL;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
`ifdef PLL_SUP_LOST_CNT_EN
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (r_lost && r_cnt != '1)
            r_cnt <= r_cnt + CNT_W'(1);
    end
    assign lost_cnt = r_cnt;
`endif
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: N-channel PLL reset/lock supervisor with registered summary flags; PLL_SUP_LOST_CNT_EN adds lost_cnt.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int CH_NUM        = 3,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int RST_CYCLES    = 16,
    parameter int MAX_RETRY     = 3,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_NUM-1:0] en,
    input  logic [CH_NUM-1:0] pll_lock,
    output logic [CH_NUM-1:0] pll_rst_o,
    output logic [CH_NUM-1:0] locked,
    output logic [CH_NUM-1:0] fail,
    output logic [CH_NUM-1:0] lost_pulse,
    output logic              all_locked,
    output logic              any_fail
`ifdef PLL_SUP_LOST_CNT_EN
    , output logic [CH_NUM*CNT_W-1:0] lost_cnt
`endif
);
    logic r_all, r_any;
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        pll_sup_chan #(
            .LOCK_TIMEOUT (LOCK_TIMEOUT),
            .RST_CYCLES   (RST_CYCLES),
            .MAX_RETRY    (MAX_RETRY),
            .STABLE_CYCLES(STABLE_CYCLES)
`ifdef PLL_SUP_LOST_CNT_EN
            , .CNT_W      (CNT_W)
`endif
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (en[i]),
            .pll_lock  (pll_lock[i]),
            .pll_rst_o (pll_rst_o[i]),
            .locked    (locked[i]),
            .fail      (fail[i]),
            .lost_pulse(lost_pulse[i])
`ifdef PLL_SUP_LOST_CNT_EN
            , .lost_cnt(lost_cnt[i*CNT_W +: CNT_W])
`endif
        );
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_all <= 1'b0;
            r_any <= 1'b0;
        end else begin
            r_all <= (|en) && (&(locked | ~en));
            r_any <= |fail;
        end
    end
    assign all_locked = r_all;
    assign any_fail   = r_any;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: randomized scenarios with an event-time reference model feeding per-stream expectation queues.
module tb_pll_lock_supervisor;
    localparam int R = 4, T = 100, S = 8;
    localparam int K_RR = 0, K_RF = 1, K_LR = 2, K_LF = 3, K_LP = 4, K_FR = 5;
    localparam int K_FF = 6, K_CN = 7, K_AR = 8, K_AF = 9, K_XR = 10, K_XF = 11;
    logic       clk = 1'b0, rst = 1'b1;
    logic [2:0] en = '0, pll_lock = '0;
    logic [2:0] pll_rst_o, locked, fail, lost_pulse;
    logic       all_locked, any_fail;
`ifdef PLL_SUP_LOST_CNT_EN
    logic [23:0] lost_cnt;
`endif
    int cyc = 0, n_pass = 0, n_tot = 0;
    int q[48][$];
    int qv[3][$];
    int m_cnt[3] = '{0, 0, 0};

    pll_lock_supervisor #(
        .CH_NUM(3), .LOCK_TIMEOUT(T), .RST_CYCLES(R), .MAX_RETRY(2), .STABLE_CYCLES(S), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pll_lock(pll_lock), .pll_rst_o(pll_rst_o),
        .locked(locked), .fail(fail), .lost_pulse(lost_pulse),
        .all_locked(all_locked), .any_fail(any_fail)
`ifdef PLL_SUP_LOST_CNT_EN
        , .lost_cnt(lost_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_RR: return "rst_rise";   K_RF: return "rst_fall";
            K_LR: return "lock_rise";  K_LF: return "lock_fall";
            K_LP: return "lost_pulse"; K_FR: return "fail_rise";
            K_FF: return "fail_fall";  K_CN: return "lost_cnt";
            K_AR: return "all_rise";   K_AF: return "all_fall";
            K_XR: return "anyf_rise";  default: return "anyf_fall";
        endcase
    endfunction

    task automatic push(input int s, input int k, input int c, input int v = 0);
        q[s*12+k].push_back(c);
        if (k == K_CN) qv[s].push_back(v);
    endtask

    task automatic got(input int s, input int k, input int v);
        int w, wv;
        n_tot++;
        if (q[s*12+k].size() == 0) begin
            $display("FAIL %s s%0d unexpected at cyc %0d val %0d", kname(k), s, cyc, v);
        end else begin
            w  = q[s*12+k].pop_front();
            wv = v;
            if (k == K_CN) wv = qv[s].pop_front();
            if (w == cyc && wv == v) n_pass++;
            else $display("FAIL %s s%0d got cyc %0d val %0d, want cyc %0d val %0d", kname(k), s, cyc, v, w, wv);
        end
    endtask

    task automatic chk(input string nm, input int g, input int w);
        n_tot++;
        if (g == w) n_pass++;
        else $display("FAIL %s got %0d want %0d", nm, g, w);
    endtask

    logic [2:0]  p_rst = '0, p_lck = '0, p_fl = '0;
    logic        p_all = 1'b0, p_af = 1'b0;
    logic [23:0] p_cnt = '0;
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (pll_rst_o[c] != p_rst[c]) got(c, pll_rst_o[c] ? K_RR : K_RF, 0);
            if (locked[c] != p_lck[c]) got(c, locked[c] ? K_LR : K_LF, 0);
            if (fail[c] != p_fl[c]) got(c, fail[c] ? K_FR : K_FF, 0);
            if (lost_pulse[c]) got(c, K_LP, 0);
`ifdef PLL_SUP_LOST_CNT_EN
            if (lost_cnt[c*8 +: 8] != p_cnt[c*8 +: 8]) got(c, K_CN, int'(lost_cnt[c*8 +: 8]));
`endif
        end
        if (all_locked != p_all) got(3, all_locked ? K_AR : K_AF, 0);
        if (any_fail != p_af) got(3, any_fail ? K_XR : K_XF, 0);
        p_rst = pll_rst_o;
        p_lck = locked;
        p_fl  = fail;
        p_all = all_locked;
        p_af  = any_fail;
`ifdef PLL_SUP_LOST_CNT_EN
        p_cnt = lost_cnt;
`endif
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic until_cyc(input int c);
        step(c - cyc);
    endtask

    // Lock dropped after edge n: loss seen 3 edges later, one reset pulse, relock d cycles after the drop.
    task automatic lose(input int ch, input int d, output int lt);
        int n;
        n = cyc;
        pll_lock[ch] = 1'b0;
        push(ch, K_LP, n + 3);
        push(ch, K_LF, n + 3);
        push(ch, K_RR, n + 3);
        push(ch, K_RF, n + 3 + R);
`ifdef PLL_SUP_LOST_CNT_EN
        if (m_cnt[ch] < 255) begin
            m_cnt[ch]++;
            push(ch, K_CN, n + 4, m_cnt[ch]);
        end
`endif
        lt = ((n + d + 2 > n + 3 + R) ? n + d + 2 : n + 3 + R) + S;
        if (d > 0) begin
            push(ch, K_LR, lt);
            step(d);
            pll_lock[ch] = 1'b1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " pll_rst_o"}, int'(pll_rst_o), 0);
        chk({tag, " locked"}, int'(locked), 0);
        chk({tag, " fail"}, int'(fail), 0);
        chk({tag, " lost_pulse"}, int'(lost_pulse), 0);
        chk({tag, " all_locked"}, int'(all_locked), 0);
        chk({tag, " any_fail"}, int'(any_fail), 0);
`ifdef PLL_SUP_LOST_CNT_EN
        chk({tag, " lost_cnt"}, int'(lost_cnt), 0);
`endif
    endtask

    initial begin
        int n, w, lt, p, a, h, g, q0;
        step(3);
        chk_zero("reset");
        rst = 1'b0;
        step(2);
        n = cyc;
        en = '1;
        for (int c = 0; c < 3; c++) begin
            push(c, K_RR, n + 1);
            push(c, K_RF, n + 1 + R);
        end
        w = n + 1 + R;
        until_cyc(w + 20);
        pll_lock = '1;
        for (int c = 0; c < 3; c++) push(c, K_LR, w + 30);
        push(3, K_AR, w + 31);
        until_cyc(w + 40);
        chk("nominal locked", int'(locked), 7);
        n = cyc;
        lose(1, 0, lt);
        push(3, K_AF, n + 4);
        w = n + 3 + R;
        for (int r = 0; r < 2; r++) begin
            push(1, K_RR, w + T);
            push(1, K_RF, w + T + R);
            w = w + T + R;
        end
        push(1, K_FR, w + T);
        push(3, K_XR, w + T + 1);
        until_cyc(w + T + 5);
        chk("timeout fail", int'(fail), 2);
        chk("timeout locked", int'(locked), 5);
        lose(0, $urandom_range(20, 40), lt);
        until_cyc(lt + 3);
`ifdef PLL_SUP_LOST_CNT_EN
        chk("loss cnt0", int'(lost_cnt[7:0]), 1);
`endif
        lose(2, 0, lt);
        w = cyc + 3 + R;
        a = $urandom_range(3, 20);
        h = $urandom_range(1, 7);
        g = $urandom_range(1, 4);
        until_cyc(w + a);
        p = cyc;
        pll_lock[2] = 1'b1;
        step(h);
        pll_lock[2] = 1'b0;
        step(g);
        pll_lock[2] = 1'b1;
        push(2, K_LR, p + h + g + 10);
        until_cyc(p + h + g + 13);
        repeat (300) begin
            lose(0, 1, lt);
            until_cyc(lt + $urandom_range(0, 2));
        end
        step(3);
`ifdef PLL_SUP_LOST_CNT_EN
        chk("saturated cnt0", int'(lost_cnt[7:0]), 255);
`endif
        n = cyc;
        pll_lock[2] = 1'b0;
        push(2, K_LP, n + 3);
        push(2, K_LF, n + 3);
        push(2, K_RR, n + 3);
        push(2, K_RF, n + 5);
`ifdef PLL_SUP_LOST_CNT_EN
        m_cnt[2]++;
        push(2, K_CN, n + 4, m_cnt[2]);
`endif
        step(4);
        en[2] = 1'b0;
        step(6);
        q0 = cyc;
        rst = 1'b1;
        push(0, K_LF, q0 + 1);
        push(1, K_FF, q0 + 1);
        push(3, K_XF, q0 + 1);
`ifdef PLL_SUP_LOST_CNT_EN
        for (int c = 0; c < 3; c++) begin
            if (m_cnt[c] != 0) push(c, K_CN, q0 + 1, 0);
            m_cnt[c] = 0;
        end
`endif
        step(1);
        rst = 1'b0;
        chk_zero("mid-run rst");
        for (int c = 0; c < 2; c++) begin
            push(c, K_RR, q0 + 2);
            push(c, K_RF, q0 + 2 + R);
        end
        push(0, K_LR, q0 + 2 + R + S);
        until_cyc(q0 + 20);
        chk("post-rst locked", int'(locked), 1);
        for (int i = 0; i < 48; i++) begin
            while (q[i].size() > 0) begin
                n_tot++;
                $display("FAIL %s s%0d missing, want cyc %0d", kname(i % 12), i / 12, q[i].pop_front());
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
